// File: rtl/alu_reservation_station_if.sv
// Shared ALU operand/flag types and the port bundle between the rename/issue
// stage, the common data bus, the reservation station and the ALU execute unit.
package data_structures;
    localparam int GPR_SIZE = 64;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR,
        ALU_LSL, ALU_LSR, ALU_ASR, ALU_MOV
    } alu_op_t;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;
endpackage

interface alu_reservation_station_if #(parameter int TAG_W = 4);
    import data_structures::*;

    // Handshakes (issue: in_issue_valid/out_issue_ready, dispatch: out_fu_valid/in_fu_ready):
    // a transfer happens on a rising edge where valid && ready; the producer holds its
    // payload stable while valid && !ready, and no ready signal depends on its valid.
    logic                in_flush;
    logic                in_issue_valid;
    logic                out_issue_ready;
    alu_op_t             in_alu_op;
    logic [5:0]          in_alu_val_hw;
    logic                in_set_CC;
    cond_t               in_cond;
    logic [GPR_SIZE-1:0] in_val_a;
    logic [GPR_SIZE-1:0] in_val_b;
    logic                in_rdy_a;
    logic                in_rdy_b;
    logic [TAG_W-1:0]    in_tag_a;
    logic [TAG_W-1:0]    in_tag_b;
    nzcv_t               in_nzcv;
    logic                in_rdy_nzcv;
    logic [TAG_W-1:0]    in_tag_nzcv;
    logic [TAG_W-1:0]    in_dst_tag;
    logic                in_cdb_valid;
    logic [TAG_W-1:0]    in_cdb_tag;
    logic [GPR_SIZE-1:0] in_cdb_val;
    logic                in_cdb_set_nzcv;
    nzcv_t               in_cdb_nzcv;
    logic                out_fu_valid;
    logic                in_fu_ready;
    alu_op_t             out_alu_op;
    logic [GPR_SIZE-1:0] out_val_a;
    logic [GPR_SIZE-1:0] out_val_b;
    logic [5:0]          out_alu_val_hw;
    logic                out_set_CC;
    cond_t               out_cond;
    nzcv_t               out_prev_nzcv;
    logic [TAG_W-1:0]    out_dst_tag;

    modport master (
        output in_flush, in_issue_valid, in_alu_op, in_alu_val_hw, in_set_CC, in_cond,
               in_val_a, in_val_b, in_rdy_a, in_rdy_b, in_tag_a, in_tag_b,
               in_nzcv, in_rdy_nzcv, in_tag_nzcv, in_dst_tag,
               in_cdb_valid, in_cdb_tag, in_cdb_val, in_cdb_set_nzcv, in_cdb_nzcv, in_fu_ready,
        input  out_issue_ready, out_fu_valid, out_alu_op, out_val_a, out_val_b,
               out_alu_val_hw, out_set_CC, out_cond, out_prev_nzcv, out_dst_tag
    );

    modport slave (
        input  in_flush, in_issue_valid, in_alu_op, in_alu_val_hw, in_set_CC, in_cond,
               in_val_a, in_val_b, in_rdy_a, in_rdy_b, in_tag_a, in_tag_b,
               in_nzcv, in_rdy_nzcv, in_tag_nzcv, in_dst_tag,
               in_cdb_valid, in_cdb_tag, in_cdb_val, in_cdb_set_nzcv, in_cdb_nzcv, in_fu_ready,
        output out_issue_ready, out_fu_valid, out_alu_op, out_val_a, out_val_b,
               out_alu_val_hw, out_set_CC, out_cond, out_prev_nzcv, out_dst_tag
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers renamed ops, wakes operands from the CDB and
// dispatches the oldest ready op into a registered execute-unit stage.
module alu_reservation_station
    import data_structures::*;
#(
    parameter int RS_ENTRIES = 4,
    parameter int TAG_W      = 4
) (
    input logic                      in_clk,
    input logic                      in_rst_n,
    alu_reservation_station_if.slave bus
);
    localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

    typedef struct packed {
        logic                valid;
        alu_op_t             alu_op;
        logic [5:0]          alu_val_hw;
        logic                set_cc;
        cond_t               cond;
        logic [GPR_SIZE-1:0] val_a;
        logic                rdy_a;
        logic [TAG_W-1:0]    tag_a;
        logic [GPR_SIZE-1:0] val_b;
        logic                rdy_b;
        logic [TAG_W-1:0]    tag_b;
        nzcv_t               nzcv;
        logic                rdy_nzcv;
        logic [TAG_W-1:0]    tag_nzcv;
        logic [TAG_W-1:0]    dst_tag;
        logic [7:0]          age;
    } rs_entry_t;

    typedef struct packed {
        alu_op_t             alu_op;
        logic [GPR_SIZE-1:0] val_a;
        logic [GPR_SIZE-1:0] val_b;
        logic [5:0]          alu_val_hw;
        logic                set_cc;
        cond_t               cond;
        nzcv_t               prev_nzcv;
        logic [TAG_W-1:0]    dst_tag;
    } disp_t;

    rs_entry_t             ent_q [RS_ENTRIES];
    logic [7:0]            age_cnt_q;
    logic                  fu_valid_q;
    disp_t                 disp_q;

    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [RS_ENTRIES-1:0] eligible;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic [7:0]            sel_age;
    logic [7:0]            age_diff;
    logic                  issue_fire;
    logic                  load;
    rs_entry_t             issue_ent;

    // Lowest-index free slot; scanning downward leaves the smallest hit.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Oldest-first select on pre-edge ready bits; the signed 8-bit age difference
    // survives counter wrap, and strict "older" keeps ties on the lower index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        age_diff  = '0;
        eligible  = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            eligible[i] = ent_q[i].valid && ent_q[i].rdy_a && ent_q[i].rdy_b && ent_q[i].rdy_nzcv;
            age_diff    = ent_q[i].age - sel_age;
            if (eligible[i] && (!sel_found || age_diff[7])) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = ent_q[i].age;
            end
        end
    end

    assign issue_fire = bus.in_issue_valid && free_found;
    assign load       = sel_found && (!fu_valid_q || bus.in_fu_ready);

    // Incoming entry, with same-cycle CDB bypass for any unready operand.
    always_comb begin
        issue_ent            = '0;
        issue_ent.valid      = 1'b1;
        issue_ent.alu_op     = bus.in_alu_op;
        issue_ent.alu_val_hw = bus.in_alu_val_hw;
        issue_ent.set_cc     = bus.in_set_CC;
        issue_ent.cond       = bus.in_cond;
        issue_ent.tag_a      = bus.in_tag_a;
        issue_ent.tag_b      = bus.in_tag_b;
        issue_ent.tag_nzcv   = bus.in_tag_nzcv;
        issue_ent.dst_tag    = bus.in_dst_tag;
        issue_ent.age        = age_cnt_q;
        issue_ent.rdy_a      = bus.in_rdy_a || (bus.in_cdb_valid && bus.in_cdb_tag == bus.in_tag_a);
        issue_ent.val_a      = bus.in_rdy_a ? bus.in_val_a : bus.in_cdb_val;
        issue_ent.rdy_b      = bus.in_rdy_b || (bus.in_cdb_valid && bus.in_cdb_tag == bus.in_tag_b);
        issue_ent.val_b      = bus.in_rdy_b ? bus.in_val_b : bus.in_cdb_val;
        issue_ent.rdy_nzcv   = bus.in_rdy_nzcv ||
                               (bus.in_cdb_valid && bus.in_cdb_set_nzcv && bus.in_cdb_tag == bus.in_tag_nzcv);
        issue_ent.nzcv       = bus.in_rdy_nzcv ? bus.in_nzcv : bus.in_cdb_nzcv;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < RS_ENTRIES; i++) ent_q[i] <= '0;
            age_cnt_q  <= '0;
            fu_valid_q <= 1'b0;
            disp_q     <= '0;
        end else if (bus.in_flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) ent_q[i].valid <= 1'b0;
            fu_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (ent_q[i].valid) begin
                    if (!ent_q[i].rdy_a && bus.in_cdb_valid && bus.in_cdb_tag == ent_q[i].tag_a) begin
                        ent_q[i].val_a <= bus.in_cdb_val;
                        ent_q[i].rdy_a <= 1'b1;
                    end
                    if (!ent_q[i].rdy_b && bus.in_cdb_valid && bus.in_cdb_tag == ent_q[i].tag_b) begin
                        ent_q[i].val_b <= bus.in_cdb_val;
                        ent_q[i].rdy_b <= 1'b1;
                    end
                    if (!ent_q[i].rdy_nzcv && bus.in_cdb_valid && bus.in_cdb_set_nzcv &&
                        bus.in_cdb_tag == ent_q[i].tag_nzcv) begin
                        ent_q[i].nzcv     <= bus.in_cdb_nzcv;
                        ent_q[i].rdy_nzcv <= 1'b1;
                    end
                    if (load && sel_idx == IDX_W'(i)) ent_q[i].valid <= 1'b0;
                end
            end
            // Issue only targets an invalid slot, so it never collides with the freed one.
            if (issue_fire) begin
                ent_q[free_idx] <= issue_ent;
                age_cnt_q       <= age_cnt_q + 8'd1;
            end
            if (load) begin
                fu_valid_q        <= 1'b1;
                disp_q.alu_op     <= ent_q[sel_idx].alu_op;
                disp_q.val_a      <= ent_q[sel_idx].val_a;
                disp_q.val_b      <= ent_q[sel_idx].val_b;
                disp_q.alu_val_hw <= ent_q[sel_idx].alu_val_hw;
                disp_q.set_cc     <= ent_q[sel_idx].set_cc;
                disp_q.cond       <= ent_q[sel_idx].cond;
                disp_q.prev_nzcv  <= ent_q[sel_idx].nzcv;
                disp_q.dst_tag    <= ent_q[sel_idx].dst_tag;
            end else if (bus.in_fu_ready) begin
                fu_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_issue_ready = free_found;
    assign bus.out_fu_valid    = fu_valid_q;
    assign bus.out_alu_op      = disp_q.alu_op;
    assign bus.out_val_a       = disp_q.val_a;
    assign bus.out_val_b       = disp_q.val_b;
    assign bus.out_alu_val_hw  = disp_q.alu_val_hw;
    assign bus.out_set_CC      = disp_q.set_cc;
    assign bus.out_cond        = disp_q.cond;
    assign bus.out_prev_nzcv   = disp_q.prev_nzcv;
    assign bus.out_dst_tag     = disp_q.dst_tag;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: issue/CDB drivers, an in-order dispatch
// scoreboard, and directed latency, wakeup, age, stall, flush and reset checks.
module tb_alu_reservation_station;
    import data_structures::*;

    localparam int TAG_W      = 4;
    localparam int RS_ENTRIES = 4;

    logic clk;
    logic rst_n;

    alu_reservation_station_if #(.TAG_W(TAG_W)) bus ();

    alu_reservation_station #(.RS_ENTRIES(RS_ENTRIES), .TAG_W(TAG_W)) dut (
        .in_clk  (clk),
        .in_rst_n(rst_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        alu_op_t             op;
        logic [5:0]          hw;
        logic                set_cc;
        cond_t               cond;
        nzcv_t               nzcv;
        logic [TAG_W-1:0]    dst;
        logic [GPR_SIZE-1:0] a;
        logic [GPR_SIZE-1:0] b;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    exp_t             mon_e;
    int               n_checks;
    int               n_fail;
    int               issue_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A dispatch transfer completes on the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && !bus.in_flush && bus.out_fu_valid && bus.in_fu_ready) begin
            check_eq("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_t'(exp_q.pop_front());
                check_eq("sb_dst",    bus.out_dst_tag,    mon_e.dst);
                check_eq("sb_op",     bus.out_alu_op,     mon_e.op);
                check_eq("sb_val_a",  bus.out_val_a,      mon_e.a);
                check_eq("sb_val_b",  bus.out_val_b,      mon_e.b);
                check_eq("sb_nzcv",   bus.out_prev_nzcv,  mon_e.nzcv);
                check_eq("sb_hw",     bus.out_alu_val_hw, mon_e.hw);
                check_eq("sb_set_cc", bus.out_set_CC,     mon_e.set_cc);
                check_eq("sb_cond",   bus.out_cond,       mon_e.cond);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_flush        = 1'b0;
        bus.in_issue_valid  = 1'b0;
        bus.in_alu_op       = ALU_ADD;
        bus.in_alu_val_hw   = '0;
        bus.in_set_CC       = 1'b0;
        bus.in_cond         = COND_EQ;
        bus.in_val_a        = '0;
        bus.in_val_b        = '0;
        bus.in_rdy_a        = 1'b0;
        bus.in_rdy_b        = 1'b0;
        bus.in_tag_a        = '0;
        bus.in_tag_b        = '0;
        bus.in_nzcv         = '0;
        bus.in_rdy_nzcv     = 1'b0;
        bus.in_tag_nzcv     = '0;
        bus.in_dst_tag      = '0;
        bus.in_cdb_valid    = 1'b0;
        bus.in_cdb_tag      = '0;
        bus.in_cdb_val      = '0;
        bus.in_cdb_set_nzcv = 1'b0;
        bus.in_cdb_nzcv     = '0;
        bus.in_fu_ready     = 1'b1;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] t, input logic [63:0] v,
                           input logic set_n, input logic [3:0] nz);
        bus.in_cdb_valid    = 1'b1;
        bus.in_cdb_tag      = t;
        bus.in_cdb_val      = v;
        bus.in_cdb_set_nzcv = set_n;
        bus.in_cdb_nzcv     = nzcv_t'(nz);
    endtask

    task automatic clr_cdb();
        bus.in_cdb_valid    = 1'b0;
        bus.in_cdb_set_nzcv = 1'b0;
    endtask

    // Drives one issue cycle. fa/fb/fn are the values the op must dispatch with:
    // driven directly when ready, otherwise delivered later (or bypassed) by the CDB.
    task automatic issue_op(input logic accept, input logic [TAG_W-1:0] dst,
                            input logic ra, input logic [TAG_W-1:0] ta, input logic [63:0] fa,
                            input logic rb, input logic [TAG_W-1:0] tb_in, input logic [63:0] fb,
                            input logic rn, input logic [TAG_W-1:0] tn, input logic [3:0] fn);
        exp_t e;
        e.op     = alu_op_t'(4'($urandom_range(0, 8)));
        e.hw     = 6'($urandom_range(0, 63));
        e.set_cc = 1'($urandom_range(0, 1));
        e.cond   = cond_t'(4'($urandom_range(0, 15)));
        e.nzcv   = nzcv_t'(fn);
        e.dst    = dst;
        e.a      = fa;
        e.b      = fb;
        bus.in_alu_op     = e.op;
        bus.in_alu_val_hw = e.hw;
        bus.in_set_CC     = e.set_cc;
        bus.in_cond       = e.cond;
        bus.in_dst_tag    = dst;
        bus.in_rdy_a      = ra;
        bus.in_tag_a      = ta;
        bus.in_val_a      = ra ? fa : {$urandom, $urandom};
        bus.in_rdy_b      = rb;
        bus.in_tag_b      = tb_in;
        bus.in_val_b      = rb ? fb : {$urandom, $urandom};
        bus.in_rdy_nzcv   = rn;
        bus.in_tag_nzcv   = tn;
        bus.in_nzcv       = rn ? nzcv_t'(fn) : nzcv_t'(4'($urandom_range(0, 15)));
        bus.in_issue_valid = 1'b1;
        step();
        bus.in_issue_valid = 1'b0;
        if (accept) begin
            exp_q.push_back(EXP_W'(e));
            issue_cnt = (issue_cnt + 1) % 256;
        end
    endtask

    task automatic issue_ready_op(input logic [TAG_W-1:0] dst);
        issue_op(1'b1, dst, 1'b1, '0, {$urandom, $urandom}, 1'b1, '0, {$urandom, $urandom},
                 1'b1, '0, 4'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check_eq("drain_done", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // X is issued into a higher slot than the younger Y, so only age decides the order.
    task automatic age_order(input string tag, input logic [TAG_W-1:0] dx, input logic [TAG_W-1:0] dy);
        issue_op(1'b1, 4'hC, 1'b0, 4'd12, 64'hAAAA, 1'b1, '0, 64'h11, 1'b1, '0, 4'h1);
        issue_op(1'b1, dx, 1'b0, 4'd2, 64'h5555, 1'b1, '0, 64'h22, 1'b1, '0, 4'h2);
        set_cdb(4'd12, 64'hAAAA, 1'b0, 4'h0);
        step();
        clr_cdb();
        step();
        check_eq({tag, "_f_first"}, bus.out_dst_tag, 4'hC);
        issue_op(1'b1, dy, 1'b0, 4'd2, 64'h5555, 1'b1, '0, 64'h33, 1'b1, '0, 4'h3);
        set_cdb(4'd2, 64'h5555, 1'b0, 4'h0);
        step();
        clr_cdb();
        step();
        check_eq({tag, "_x_valid"}, bus.out_fu_valid, 1'b1);
        check_eq({tag, "_x_first"}, bus.out_dst_tag, dx);
        step();
        check_eq({tag, "_y_next"}, bus.out_dst_tag, dy);
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        issue_cnt = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_issue_ready", bus.out_issue_ready, 1'b1);
        check_eq("rst_fu_valid",    bus.out_fu_valid,    1'b0);
        check_eq("rst_val_a",       bus.out_val_a,       64'd0);
        check_eq("rst_val_b",       bus.out_val_b,       64'd0);
        check_eq("rst_dst_tag",     bus.out_dst_tag,     64'd0);
        check_eq("rst_alu_op",      bus.out_alu_op,      64'd0);
        check_eq("rst_prev_nzcv",   bus.out_prev_nzcv,   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First issue lands on the first edge after reset; two edges to dispatch.
        issue_op(1'b1, 4'hA, 1'b1, '0, 64'h1111, 1'b1, '0, 64'h2222, 1'b1, '0, 4'h5);
        check_eq("latency_edge1", bus.out_fu_valid, 1'b0);
        step();
        check_eq("latency_edge2", bus.out_fu_valid, 1'b1);
        check_eq("latency_dst",   bus.out_dst_tag,  4'hA);
        drain();

        // Fill with A waiting on tag 9, reject a fifth, then free and reissue together.
        for (int i = 0; i < 4; i++) begin
            issue_op(1'b1, TAG_W'(i + 1), 1'b0, 4'd9, 64'hF00D, 1'b1, '0, 64'(i), 1'b1, '0, 4'(i));
            check_eq("fill_issue_ready", bus.out_issue_ready, 64'(i < 3));
        end
        issue_op(1'b0, 4'hE, 1'b1, '0, 64'h0, 1'b1, '0, 64'h0, 1'b1, '0, 4'h0);
        check_eq("fill_reject_ready", bus.out_issue_ready, 1'b0);
        check_eq("fill_no_dispatch",  bus.out_fu_valid,    1'b0);
        set_cdb(4'd9, 64'hF00D, 1'b0, 4'h0);
        step();
        clr_cdb();
        check_eq("capture_still_full",  bus.out_issue_ready, 1'b0);
        check_eq("capture_no_dispatch", bus.out_fu_valid,    1'b0);
        step();
        check_eq("free_dispatch",      bus.out_fu_valid,    1'b1);
        check_eq("free_visible_ready", bus.out_issue_ready, 1'b1);
        issue_ready_op(4'hB);
        check_eq("issue_and_free_ready", bus.out_issue_ready, 1'b1);
        drain();

        // Wakeup of operand A from tag 3.
        issue_op(1'b1, 4'h5, 1'b0, 4'd3, 64'h2A, 1'b1, '0, 64'h77, 1'b1, '0, 4'h6);
        set_cdb(4'd3, 64'h2A, 1'b0, 4'h0);
        step();
        clr_cdb();
        check_eq("wake_not_same_edge", bus.out_fu_valid, 1'b0);
        step();
        check_eq("wake_fu_valid", bus.out_fu_valid, 1'b1);
        check_eq("wake_val_a",    bus.out_val_a,    64'h2A);
        drain();

        // Issue-cycle bypass for operand B and for NZCV.
        set_cdb(4'd5, 64'h7, 1'b0, 4'h0);
        issue_op(1'b1, 4'h1, 1'b1, '0, 64'h99, 1'b0, 4'd5, 64'h7, 1'b1, '0, 4'h0);
        clr_cdb();
        step();
        check_eq("bypass_b_valid", bus.out_fu_valid, 1'b1);
        check_eq("bypass_b_val",   bus.out_val_b,    64'h7);
        drain();
        set_cdb(4'd6, 64'h0, 1'b1, 4'hC);
        issue_op(1'b1, 4'h2, 1'b1, '0, 64'h12, 1'b1, '0, 64'h34, 1'b0, 4'd6, 4'hC);
        clr_cdb();
        step();
        check_eq("bypass_nzcv_valid", bus.out_fu_valid,  1'b1);
        check_eq("bypass_nzcv_val",   bus.out_prev_nzcv, 4'hC);
        drain();

        // NZCV wakes only on a flag-setting broadcast.
        issue_op(1'b1, 4'h6, 1'b1, '0, 64'h56, 1'b1, '0, 64'h78, 1'b0, 4'd7, 4'hA);
        set_cdb(4'd7, 64'h0, 1'b0, 4'h3);
        step();
        clr_cdb();
        repeat (2) step();
        check_eq("nzcv_needs_set", bus.out_fu_valid, 1'b0);
        set_cdb(4'd7, 64'h0, 1'b1, 4'hA);
        step();
        clr_cdb();
        step();
        check_eq("nzcv_wake_valid", bus.out_fu_valid,  1'b1);
        check_eq("nzcv_wake_val",   bus.out_prev_nzcv, 4'hA);
        drain();

        // Age order, then again straddling the 255 -> 0 counter wrap.
        age_order("age", 4'h6, 4'h7);
        while (issue_cnt != 254) issue_ready_op(4'($urandom_range(0, 15)));
        drain();
        age_order("age_wrap", 4'h8, 4'h9);

        // Stall: outputs hold while the execute unit refuses.
        bus.in_fu_ready = 1'b0;
        issue_op(1'b1, 4'h1, 1'b1, '0, 64'hA0, 1'b1, '0, 64'hA1, 1'b1, '0, 4'h1);
        issue_op(1'b1, 4'h2, 1'b1, '0, 64'hB0, 1'b1, '0, 64'hB1, 1'b1, '0, 4'h2);
        issue_op(1'b1, 4'h3, 1'b1, '0, 64'hC0, 1'b1, '0, 64'hC1, 1'b1, '0, 4'h3);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", bus.out_fu_valid, 1'b1);
            check_eq("stall_dst",   bus.out_dst_tag,  4'h1);
            check_eq("stall_val_a", bus.out_val_a,    64'hA0);
            step();
        end
        bus.in_fu_ready = 1'b1;
        step();
        check_eq("stall_release_next", bus.out_dst_tag, 4'h2);
        drain();

        // Flush with a full station and a held dispatch; same-cycle issue/CDB ignored.
        bus.in_fu_ready = 1'b0;
        issue_ready_op(4'h8);
        for (int i = 0; i < 4; i++)
            issue_op(1'b1, TAG_W'(i + 9), 1'b0, 4'd15, 64'h0, 1'b1, '0, 64'h0, 1'b1, '0, 4'h0);
        check_eq("flush_pre_full",  bus.out_issue_ready, 1'b0);
        check_eq("flush_pre_valid", bus.out_fu_valid,    1'b1);
        bus.in_flush = 1'b1;
        set_cdb(4'd15, 64'h1, 1'b1, 4'hF);
        issue_op(1'b0, 4'hD, 1'b1, '0, 64'h0, 1'b1, '0, 64'h0, 1'b1, '0, 4'h0);
        bus.in_flush = 1'b0;
        clr_cdb();
        exp_q.delete();
        check_eq("flush_fu_valid",    bus.out_fu_valid,    1'b0);
        check_eq("flush_issue_ready", bus.out_issue_ready, 1'b1);
        bus.in_fu_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("flush_stays_empty", bus.out_fu_valid, 1'b0);
        end

        // Asynchronous reset between edges, then first-edge issue after release.
        bus.in_fu_ready = 1'b0;
        issue_ready_op(4'h3);
        step();
        check_eq("pre_reset_valid", bus.out_fu_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_fu_valid",    bus.out_fu_valid,    1'b0);
        check_eq("async_rst_issue_ready", bus.out_issue_ready, 1'b1);
        check_eq("async_rst_val_a",       bus.out_val_a,       64'd0);
        check_eq("async_rst_dst",         bus.out_dst_tag,     64'd0);
        exp_q.delete();
        issue_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_fu_ready = 1'b1;
        issue_ready_op(4'h4);
        check_eq("post_rst_edge1", bus.out_fu_valid, 1'b0);
        step();
        check_eq("post_rst_edge2", bus.out_fu_valid, 1'b1);
        check_eq("post_rst_dst",   bus.out_dst_tag,  4'h4);
        drain();

        check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
